// File: rtl/cache_memory_bus.sv
// cache_memory_bus
//   Arbitrates line fills and line write-backs from a data cache (client 0)
//   and an instruction cache (client 1) onto a single AXI4 master port, one
//   16-beat burst at a time. The data cache wins when both request together.
//
// Ports
//   clk, reset            : single clock, asynchronous active-high reset
//   command_valid/store   : per-client request and fill(0)/write-back(1) flag
//   command_rready        : per-client response acknowledge
//   command_addr, data_in : per-client address and write-back line
//   bus_ready, bus_valid  : per-client command accept / response valid
//   data_out              : most recently filled line, shared by both clients
//   invalidate(_addr)     : snoop invalidate pulse and its address
//   m_axi_*               : AXI4 master channels plus ACE snoop address channel
//
// Configuration
//   CACHE_BUS_SNOOP_EN    : when defined, snoop addresses on the AC channel are
//                           turned into one-cycle invalidate pulses; otherwise
//                           the snoop outputs are tied off.
module cache_memory_bus #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 command_valid,
  input  logic [1:0]                 command_store,
  input  logic [1:0]                 command_rready,
  input  logic [2*ADDR_WIDTH-1:0]    command_addr,
  input  logic [2*16*DATA_WIDTH-1:0] data_in,
  output logic [1:0]                 bus_ready,
  output logic [1:0]                 bus_valid,
  output logic [16*DATA_WIDTH-1:0]   data_out,
  output logic                       invalidate,
  output logic [ADDR_WIDTH-1:0]      invalidate_addr,
  output logic [ID_WIDTH-1:0]        m_axi_awid,
  output logic [ADDR_WIDTH-1:0]      m_axi_awaddr,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic                       m_axi_awlock,
  output logic [3:0]                 m_axi_awcache,
  output logic [2:0]                 m_axi_awprot,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [DATA_WIDTH-1:0]      m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]    m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic [ID_WIDTH-1:0]        m_axi_bid,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,
  output logic [ID_WIDTH-1:0]        m_axi_arid,
  output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arlock,
  output logic [3:0]                 m_axi_arcache,
  output logic [2:0]                 m_axi_arprot,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [ID_WIDTH-1:0]        m_axi_rid,
  input  logic [DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  input  logic                       m_axi_acvalid,
  output logic                       m_axi_acready,
  input  logic [ADDR_WIDTH-1:0]      m_axi_acaddr,
  input  logic [3:0]                 m_axi_acsnoop
);

  localparam int BEATS  = 16;
  localparam int LINE_W = BEATS * DATA_WIDTH;
  localparam int OFFSET = $clog2(LINE_W / 8);  // byte offset bits within a line

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RESP} state_t;

  state_t                  state;
  logic                    grant;       // 0 = data cache, 1 = instruction cache
  logic [ADDR_WIDTH-1:0]   line_addr;
  logic [LINE_W-1:0]       wr_line;
  logic [3:0]              beat;
  logic [DATA_WIDTH-1:0]   line_beats [BEATS];

  // Data cache has priority, so the instruction cache is picked only when
  // the data cache is idle.
  logic       pick;
  logic       pick_store;
  logic [1:0] grant_onehot;

  assign pick         = ~command_valid[0];
  assign pick_store   = pick ? command_store[1] : command_store[0];
  assign grant_onehot = grant ? 2'b10 : 2'b01;

  // Accept is combinational so the pulse lands in the same IDLE cycle in
  // which the request is latched.
  assign bus_ready = (state == IDLE && !reset && command_valid[0]) ? 2'b01 :
                     (state == IDLE && !reset && command_valid[1]) ? 2'b10 : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= 1'b0;
      line_addr     <= '0;
      wr_line       <= '0;
      beat          <= '0;
      bus_valid     <= 2'b00;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wlast   <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|command_valid) begin
          grant     <= pick;
          line_addr <= pick ? command_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : command_addr[ADDR_WIDTH-1:0];
          wr_line   <= pick ? data_in[2*LINE_W-1:LINE_W] : data_in[LINE_W-1:0];
          if (pick_store) begin
            m_axi_awvalid <= 1'b1;
            state         <= AW;
          end else begin
            m_axi_arvalid <= 1'b1;
            state         <= AR;
          end
        end
        AR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
          beat          <= '0;
          state         <= R;
        end
        R: if (m_axi_rvalid) begin
          beat <= beat + 4'd1;
          // A missing rlast on the last beat still ends the burst.
          if (m_axi_rlast || beat == 4'd15) begin
            m_axi_rready <= 1'b0;
            bus_valid    <= grant_onehot;
            state        <= RESP;
          end
        end
        AW: if (m_axi_awready) begin
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b1;
          m_axi_wlast   <= 1'b0;
          beat          <= '0;
          state         <= W;
        end
        W: if (m_axi_wready) begin
          beat <= beat + 4'd1;
          if (beat == 4'd15) begin
            m_axi_wvalid <= 1'b0;
            m_axi_wlast  <= 1'b0;
            m_axi_bready <= 1'b1;
            state        <= B;
          end else begin
            // Registered wlast: raise it as beat 15 becomes current.
            m_axi_wlast <= (beat == 4'd14);
          end
        end
        B: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          bus_valid    <= grant_onehot;
          state        <= RESP;
        end
        RESP: if (command_rready[grant]) begin
          bus_valid <= 2'b00;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One register slot per beat of the fill line; each slot is only written
  // when its beat arrives, so the line persists until the next fill.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          line_beats[gi] <= '0;
        else if (state == R && m_axi_rvalid && beat == 4'(gi))
          line_beats[gi] <= m_axi_rdata;
      end
      assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = line_beats[gi];
    end
  endgenerate

  assign m_axi_araddr  = {line_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
  assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, grant};
  assign m_axi_arlen   = 8'd15;
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;

  assign m_axi_awaddr  = m_axi_araddr;
  assign m_axi_awid    = m_axi_arid;
  assign m_axi_awlen   = 8'd15;
  assign m_axi_awsize  = m_axi_arsize;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;

  assign m_axi_wdata = wr_line[int'(beat) * DATA_WIDTH +: DATA_WIDTH];
  assign m_axi_wstrb = {(DATA_WIDTH/8){m_axi_wvalid}};

`ifdef CACHE_BUS_SNOOP_EN
  assign m_axi_acready = ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      invalidate      <= 1'b0;
      invalidate_addr <= '0;
    end else begin
      invalidate <= m_axi_acvalid;
      if (m_axi_acvalid)
        invalidate_addr <= m_axi_acaddr;
    end
  end

  logic unused;
  assign unused = ^{m_axi_rid, m_axi_rresp, m_axi_bid, m_axi_bresp, m_axi_acsnoop,
                    line_addr[OFFSET-1:0]};
`else
  assign m_axi_acready   = 1'b1;
  assign invalidate      = 1'b0;
  assign invalidate_addr = '0;

  logic unused;
  assign unused = ^{m_axi_rid, m_axi_rresp, m_axi_bid, m_axi_bresp, m_axi_acsnoop,
                    m_axi_acvalid, m_axi_acaddr, line_addr[OFFSET-1:0]};
`endif

endmodule

// File: tb/tb_cache_memory_bus.sv
module tb_cache_memory_bus;

  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int LW  = 16 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [1:0]        command_valid, command_store, command_rready;
  logic [2*AW-1:0]   command_addr;
  logic [2*LW-1:0]   data_in;
  logic [1:0]        bus_ready, bus_valid;
  logic [LW-1:0]     data_out;
  logic              invalidate;
  logic [AW-1:0]     invalidate_addr;
  logic [IDW-1:0]    m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [AW-1:0]     m_axi_awaddr, m_axi_araddr, m_axi_acaddr;
  logic [7:0]        m_axi_awlen, m_axi_arlen;
  logic [2:0]        m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]        m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic              m_axi_awlock, m_axi_arlock;
  logic [3:0]        m_axi_awcache, m_axi_arcache, m_axi_acsnoop;
  logic              m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0]     m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0]   m_axi_wstrb;
  logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic              m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic              m_axi_acvalid, m_axi_acready;

  cache_memory_bus #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .command_valid(command_valid), .command_store(command_store),
    .command_rready(command_rready), .command_addr(command_addr), .data_in(data_in),
    .bus_ready(bus_ready), .bus_valid(bus_valid), .data_out(data_out),
    .invalidate(invalidate), .invalidate_addr(invalidate_addr),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_acvalid(m_axi_acvalid), .m_axi_acready(m_axi_acready),
    .m_axi_acaddr(m_axi_acaddr), .m_axi_acsnoop(m_axi_acsnoop)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  // Reference model: the last line delivered by a completed or partial fill.
  logic [DW-1:0] model_line [16];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_line(input string tag);
    for (int i = 0; i < 16; i++) check(tag, data_out[i*DW +: DW], model_line[i]);
  endtask

  // One granted transaction, from the cycle after the grant to the return to IDLE.
  task automatic serve(input int k, input bit store, input logic [AW-1:0] a,
                       input logic [LW-1:0] wline, input bit rst_mid, output bit aborted);
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] rline [16];
    logic [1:0]    exp_valid;
    int            n;
    int            cnt;
    exp_addr  = {a[AW-1:7], 7'b0};
    exp_valid = (k == 1) ? 2'b10 : 2'b01;
    aborted   = 1'b0;
    check("busy_no_ready", bus_ready, 2'b00);
    if (!store) begin
      check("arvalid", m_axi_arvalid, 1'b1);
      check("awvalid_idle", m_axi_awvalid, 1'b0);
      check("araddr", m_axi_araddr, exp_addr);
      check("arlen", m_axi_arlen, 8'd15);
      check("arsize", m_axi_arsize, 3'd3);
      check("arburst", m_axi_arburst, 2'b01);
      check("arid", m_axi_arid, k);
      repeat ($urandom_range(0, 3)) begin
        tick();
        check("ar_hold", m_axi_arvalid, 1'b1);
      end
      m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0;
      check("ar_drop", m_axi_arvalid, 1'b0);
      for (n = 0; n < 16; n++) begin
        m_axi_rvalid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        if (rst_mid && n == 7) begin
          reset = 1'b1;
          #1;
          check("rst_rready", m_axi_rready, 1'b0);
          check("rst_arvalid", m_axi_arvalid, 1'b0);
          check("rst_wvalid", m_axi_wvalid, 1'b0);
          check("rst_bus_valid", bus_valid, 2'b00);
          check("rst_bus_ready", bus_ready, 2'b00);
          check("rst_data0", data_out[DW-1:0], 64'd0);
          check("rst_wstrb", m_axi_wstrb, 8'd0);
          tick();
          reset = 1'b0;
          for (int i = 0; i < 16; i++) model_line[i] = '0;
          aborted = 1'b1;
          return;
        end
        rline[n]     = {$urandom, $urandom};
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = rline[n];
        m_axi_rlast  = (n == 15) && ($urandom_range(0, 3) != 0);
        m_axi_rid    = IDW'($urandom);
        m_axi_rresp  = 2'($urandom);
        check("rready", m_axi_rready, 1'b1);
        tick();
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      for (int i = 0; i < 16; i++) model_line[i] = rline[i];
    end else begin
      check("awvalid", m_axi_awvalid, 1'b1);
      check("arvalid_idle", m_axi_arvalid, 1'b0);
      check("awaddr", m_axi_awaddr, exp_addr);
      check("awlen", m_axi_awlen, 8'd15);
      check("awsize", m_axi_awsize, 3'd3);
      check("awburst", m_axi_awburst, 2'b01);
      check("awid", m_axi_awid, k);
      repeat ($urandom_range(0, 3)) begin
        tick();
        check("aw_hold", m_axi_awvalid, 1'b1);
      end
      m_axi_awready = 1'b1;
      tick();
      m_axi_awready = 1'b0;
      n   = 0;
      cnt = 0;
      while (n < 16 && cnt < 200) begin
        m_axi_wready = ($urandom_range(0, 1) == 1) || (cnt[0] == 1'b1);
        check("wvalid", m_axi_wvalid, 1'b1);
        if (m_axi_wready) begin
          check("wdata", m_axi_wdata, wline[n*DW +: DW]);
          check("wlast", m_axi_wlast, n == 15);
          check("wstrb", m_axi_wstrb, 8'hff);
          n++;
        end
        tick();
        cnt++;
      end
      m_axi_wready = 1'b0;
      check("w_beats", n, 16);
      check("wvalid_off", m_axi_wvalid, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        check("bready", m_axi_bready, 1'b1);
        tick();
      end
      check("bready", m_axi_bready, 1'b1);
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = 2'($urandom);
      tick();
      m_axi_bvalid = 1'b0;
    end
    // Response phase: a write-back leaves the last fill line untouched.
    check("bus_valid", bus_valid, exp_valid);
    check_line("data_out");
    repeat ($urandom_range(0, 2)) begin
      command_rready[1-k] = 1'($urandom);
      tick();
      check("resp_hold", bus_valid, exp_valid);
      check("resp_no_ready", bus_ready, 2'b00);
    end
    command_rready    = 2'b00;
    command_rready[k] = 1'b1;
    tick();
    command_rready = 2'b00;
    check("resp_done", bus_valid, 2'b00);
  endtask

  // Snoop channel: random snoop traffic checked against a one-cycle-delay model.
  logic          exp_inv;
  logic [AW-1:0] exp_iaddr;
  initial begin
    m_axi_acvalid = 1'b0;
    m_axi_acaddr  = '0;
    m_axi_acsnoop = '0;
    exp_inv       = 1'b0;
    exp_iaddr     = '0;
    while (!done) begin
      @(negedge clk);
      if (reset) begin
        exp_inv = 1'b0;
      end else begin
        check("acready", m_axi_acready, 1'b1);
`ifdef CACHE_BUS_SNOOP_EN
        check("invalidate", invalidate, exp_inv);
        if (exp_inv) check("inv_addr", invalidate_addr, exp_iaddr);
`else
        check("invalidate", invalidate, 1'b0);
        check("inv_addr", invalidate_addr, 64'd0);
`endif
      end
      m_axi_acvalid = ($urandom_range(0, 3) == 0);
      m_axi_acaddr  = ($urandom_range(0, 1) == 1) ? 64'h8000_2000 : {$urandom, $urandom};
      m_axi_acsnoop = 4'($urandom);
      @(posedge clk);
      exp_inv = m_axi_acvalid && !reset;
      if (exp_inv) exp_iaddr = m_axi_acaddr;
    end
  end

  initial begin
    logic [1:0]    vm, st;
    logic [AW-1:0] ad [2];
    logic [LW-1:0] ln [2];
    bit            rst_mid, ab;
    int            k;

    reset          = 1'b1;
    command_valid  = 2'b11;
    command_store  = 2'b00;
    command_rready = 2'b00;
    command_addr   = '0;
    data_in        = '0;
    m_axi_awready  = 1'b0;
    m_axi_wready   = 1'b0;
    m_axi_bvalid   = 1'b0;
    m_axi_bid      = '0;
    m_axi_bresp    = '0;
    m_axi_arready  = 1'b0;
    m_axi_rvalid   = 1'b0;
    m_axi_rlast    = 1'b0;
    m_axi_rdata    = '0;
    m_axi_rid      = '0;
    m_axi_rresp    = '0;
    for (int i = 0; i < 16; i++) model_line[i] = '0;

    repeat (3) tick();
    check("rst_bus_ready", bus_ready, 2'b00);
    check("rst_bus_valid", bus_valid, 2'b00);
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_awvalid", m_axi_awvalid, 1'b0);
    check("rst_wvalid", m_axi_wvalid, 1'b0);
    check("rst_wstrb", m_axi_wstrb, 8'd0);
    check("rst_rready", m_axi_rready, 1'b0);
    check("rst_bready", m_axi_bready, 1'b0);
    check("rst_invalidate", invalidate, 1'b0);
    check("rst_inv_addr", invalidate_addr, 64'd0);
    check_line("rst_data_out");
    command_valid = 2'b00;
    reset         = 1'b0;
    tick();
    check("idle_no_ready", bus_ready, 2'b00);

    for (int it = 0; it < 40; it++) begin
      vm      = 2'($urandom_range(1, 3));
      st      = 2'($urandom_range(0, 3));
      rst_mid = 1'b0;
      for (int c = 0; c < 2; c++) begin
        ad[c] = {$urandom, $urandom};
        ln[c] = rand_line();
      end
      if (it == 0) begin vm = 2'b01; st = 2'b00; ad[0] = 64'h8000_1234; end
      if (it == 1) begin vm = 2'b11; st = 2'b00; end
      if (it == 2) begin
        vm = 2'b01; st = 2'b01;
        for (int i = 0; i < 16; i++) ln[0][i*DW +: DW] = 64'hA0 + 64'(i);
      end
      if (it == 5) begin vm = 2'b01; st = 2'b00; rst_mid = 1'b1; end
      command_store = st;
      command_addr  = {ad[1], ad[0]};
      data_in       = {ln[1], ln[0]};
      command_valid = vm;
      #1;
      for (int s = 0; s < 2; s++) begin
        if (s == 1 && vm != 2'b11) break;
        k = (s == 0 && vm[0]) ? 0 : 1;
        check("grant", bus_ready, (k == 1) ? 2'b10 : 2'b01);
        tick();
        // Scramble the granted client's inputs: the DUT must use its latched copy.
        command_valid[k]             = 1'b0;
        command_store[k]             = ~st[k];
        command_addr[k*AW +: AW]     = {$urandom, $urandom};
        data_in[k*LW +: LW]          = rand_line();
        serve(k, st[k], ad[k], ln[k], rst_mid, ab);
        $display("txn %0d: client %0d %s addr %h%s", it, k, st[k] ? "write-back" : "fill",
                 ad[k], ab ? " (reset mid-burst)" : "");
        if (ab) break;
        #1;
      end
      command_valid = 2'b00;
      tick();
    end

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
